// File: rtl/calculation_unit_exponent_stage.sv
`default_nettype none
// ============================================================================
//  Module   : calculation_unit_exponent_stage
//  Purpose  : Registered exponent-select stage of the calculation unit.
//             Selects the result exponent from the aligned operand exponents
//             (optionally halved with floor rounding) or from the external
//             adder/subtractor. Sign-extends the result to EXP_W+EXT_W bits
//             and flags values outside [MIN_EXP, MAX_EXP]. A valid/ready
//             output register backed by one skid entry decouples the
//             alignment stage from the normaliser.
//  Ports    : clk, reset (async, active-high), flush (sync clear)
//             in_valid / in_ready          - upstream handshake
//             exp_select [2:0]             - 0=A 1=B 2=ADD 3=SUB 4=B_SHR
//                                            5=A_SHR, 6..7 select A
//             aligned_exponent_a/b [EXP_W] - signed operand exponents
//             exponent_adder/subtractor    - signed, already OUT_W wide
//             out_valid / out_ready        - downstream handshake
//             calculated_exponent [OUT_W]  - selected exponent, signed
//             ovf_flag / unf_flag          - range flags of that exponent
//  Revision : 1.0 - initial release
// ============================================================================
module calculation_unit_exponent_stage #(
    parameter int EXP_W   = 8,
    parameter int EXT_W   = 2,
    parameter int MAX_EXP = 127,
    parameter int MIN_EXP = -126
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             exp_select,
    input  logic [EXP_W-1:0]       aligned_exponent_a,
    input  logic [EXP_W-1:0]       aligned_exponent_b,
    input  logic [EXP_W+EXT_W-1:0] exponent_adder,
    input  logic [EXP_W+EXT_W-1:0] exponent_subtractor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+EXT_W-1:0] calculated_exponent,
    output logic                   ovf_flag,
    output logic                   unf_flag
);

    localparam int c_out_w = EXP_W + EXT_W;

    localparam logic signed [c_out_w-1:0] c_max_exp = c_out_w'(MAX_EXP);
    localparam logic signed [c_out_w-1:0] c_min_exp = c_out_w'(MIN_EXP);

    // Occupancy of the stage: output register only, or output plus skid.
    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_two   = 2'd2;

    logic [1:0]               r_state;
    logic [c_out_w-1:0]       r_skid_exp;
    logic                     r_skid_ovf;
    logic                     r_skid_unf;

    logic signed [c_out_w-1:0] w_ext_a;
    logic signed [c_out_w-1:0] w_ext_b;
    logic signed [c_out_w-1:0] w_sel;
    logic                      w_ovf;
    logic                      w_unf;
    logic                      w_accept;
    logic                      w_consume;

    // ------------------------------------------------------------------
    // Exponent selection (before the pipeline register)
    // ------------------------------------------------------------------
    assign w_ext_a = {{EXT_W{aligned_exponent_a[EXP_W-1]}}, aligned_exponent_a};
    assign w_ext_b = {{EXT_W{aligned_exponent_b[EXP_W-1]}}, aligned_exponent_b};

    // Arithmetic shift of a signed value rounds toward minus infinity,
    // which is exactly floor(x/2) for the halved-exponent selections.
    always_comb begin
        w_sel = w_ext_a;
        case (exp_select)
            3'd0:    w_sel = w_ext_a;
            3'd1:    w_sel = w_ext_b;
            3'd2:    w_sel = exponent_adder;
            3'd3:    w_sel = exponent_subtractor;
            3'd4:    w_sel = w_ext_b >>> 1;
            3'd5:    w_sel = w_ext_a >>> 1;
            default: w_sel = w_ext_a;
        endcase
    end

    assign w_ovf = (w_sel > c_max_exp);
    assign w_unf = (w_sel < c_min_exp);

    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Output register + skid entry. in_ready and out_valid are kept as
    // registered copies of the occupancy so neither depends on the
    // downstream handshake combinationally.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state             <= c_st_empty;
            out_valid           <= 1'b0;
            in_ready            <= 1'b1;
            calculated_exponent <= '0;
            ovf_flag            <= 1'b0;
            unf_flag            <= 1'b0;
            r_skid_exp          <= '0;
            r_skid_ovf          <= 1'b0;
            r_skid_unf          <= 1'b0;
        end else if (flush) begin
            // Stored data is left in place; only the valid state is dropped.
            r_state   <= c_st_empty;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (w_accept) begin
                        calculated_exponent <= w_sel;
                        ovf_flag            <= w_ovf;
                        unf_flag            <= w_unf;
                        out_valid           <= 1'b1;
                        r_state             <= c_st_one;
                    end
                end
                c_st_one: begin
                    if (w_accept && w_consume) begin
                        calculated_exponent <= w_sel;
                        ovf_flag            <= w_ovf;
                        unf_flag            <= w_unf;
                    end else if (w_accept) begin
                        // Output is stalled: park the new entry in the skid.
                        r_skid_exp <= w_sel;
                        r_skid_ovf <= w_ovf;
                        r_skid_unf <= w_unf;
                        in_ready   <= 1'b0;
                        r_state    <= c_st_two;
                    end else if (w_consume) begin
                        out_valid <= 1'b0;
                        r_state   <= c_st_empty;
                    end
                end
                c_st_two: begin
                    // in_ready is low here, so only the skid-to-output move occurs.
                    if (w_consume) begin
                        calculated_exponent <= r_skid_exp;
                        ovf_flag            <= r_skid_ovf;
                        unf_flag            <= r_skid_unf;
                        in_ready            <= 1'b1;
                        r_state             <= c_st_one;
                    end
                end
                default: begin
                    r_state   <= c_st_empty;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
